// File: rtl/vga_scan_controller.sv
// VGA raster timing generator with a delay-matched blanking/sync output stage.
// Coordinates go out to the drawers; their registered RGB returns PIPE_DELAY cycles later.
module vga_scan_controller #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 48,
    parameter int H_SYNC     = 112,
    parameter int H_BP       = 248,
    parameter int V_ACTIVE   = 1024,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 38,
    parameter int SYNC_POL   = 1,
    parameter int PIPE_DELAY = 1
) (
    input  logic        CLK_VGA,
    input  logic        RESET,
    output logic [11:0] VGA_HORZ_COORD,
    output logic [11:0] VGA_VERT_COORD,
    output logic        FRAME_START,
    input  logic [3:0]  VGA_Red_In,
    input  logic [3:0]  VGA_Green_In,
    input  logic [3:0]  VGA_Blue_In,
    output logic [3:0]  VGA_RED,
    output logic [3:0]  VGA_GREEN,
    output logic [3:0]  VGA_BLUE,
    output logic        VGA_HS,
    output logic        VGA_VS
);

    localparam logic [11:0] LP_H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] LP_H_SS   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] LP_H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] LP_H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] LP_V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] LP_V_SS   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] LP_V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] LP_V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic        LP_IDLE   = (SYNC_POL == 0) ? 1'b1 : 1'b0;

    logic [11:0] r_h;
    logic [11:0] r_v;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [2:0]  w_tap;
    logic [2:0]  w_last;
    logic [PIPE_DELAY-1:0][2:0] r_dl;
    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;

    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == LP_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == LP_V_LAST) ? 12'd0 : r_v + 12'd1;
        end else begin
            r_h <= r_h + 12'd1;
        end
    end

    assign w_active = (r_h < LP_H_ACT) && (r_v < LP_V_ACT);
    assign w_hs_raw = (r_h >= LP_H_SS) && (r_h < LP_H_SE);
    assign w_vs_raw = (r_v >= LP_V_SS) && (r_v < LP_V_SE);
    assign w_tap    = {w_active, w_hs_raw, w_vs_raw};

    // Timing flags ride alongside the drawers' colour pipeline
    generate
        if (PIPE_DELAY == 1) begin : g_dl1
            always_ff @(posedge CLK_VGA) begin
                if (RESET) r_dl <= '0;
                else       r_dl <= w_tap;
            end
        end else begin : g_dln
            always_ff @(posedge CLK_VGA) begin
                if (RESET) r_dl <= '0;
                else       r_dl <= {r_dl[PIPE_DELAY-2:0], w_tap};
            end
        end
    endgenerate

    assign w_last = r_dl[PIPE_DELAY-1];

    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            r_rgb <= '0;
            r_hs  <= LP_IDLE;
            r_vs  <= LP_IDLE;
        end else begin
            r_rgb <= w_last[2] ? {VGA_Red_In, VGA_Green_In, VGA_Blue_In} : 12'h000;
            r_hs  <= w_last[1] ^ LP_IDLE;
            r_vs  <= w_last[0] ^ LP_IDLE;
        end
    end

    assign VGA_HORZ_COORD = r_h;
    assign VGA_VERT_COORD = r_v;
    assign FRAME_START    = (r_h == 12'd0) && (r_v == 12'd0);
    assign VGA_RED        = r_rgb[11:8];
    assign VGA_GREEN      = r_rgb[7:4];
    assign VGA_BLUE       = r_rgb[3:0];
    assign VGA_HS         = r_hs;
    assign VGA_VS         = r_vs;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench: two controllers (positive sync/delay 1, negative sync/delay 3) on a
// shrunken raster, checked every cycle against an arithmetic timeline model.
module tb_vga_scan_controller;

    localparam int HA = 20, HF = 3, HS = 4, HB = 5;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NCYC = 1500;
    localparam int DA = 1, DB = 3;

    logic clk = 1'b0;
    logic RESET;
    logic [11:0] rgbA, rgbB;

    logic [11:0] hA, vA, hB, vB;
    logic fsA, fsB, hsA, vsA, hsB, vsB;
    logic [3:0] rA, gA, bA, rB, gB, bB;

    bit          rst_hist [NCYC];
    logic [11:0] rgbA_hist [NCYC];
    logic [11:0] rgbB_hist [NCYC];
    bit          actH [NCYC];
    bit          hsH [NCYC];
    bit          vsH [NCYC];

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_scan_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .PIPE_DELAY(DA)
    ) u_a (
        .CLK_VGA(clk), .RESET(RESET),
        .VGA_HORZ_COORD(hA), .VGA_VERT_COORD(vA), .FRAME_START(fsA),
        .VGA_Red_In(rgbA[11:8]), .VGA_Green_In(rgbA[7:4]),
        .VGA_Blue_In(rgbA[3:0]),
        .VGA_RED(rA), .VGA_GREEN(gA), .VGA_BLUE(bA),
        .VGA_HS(hsA), .VGA_VS(vsA)
    );

    vga_scan_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .PIPE_DELAY(DB)
    ) u_b (
        .CLK_VGA(clk), .RESET(RESET),
        .VGA_HORZ_COORD(hB), .VGA_VERT_COORD(vB), .FRAME_START(fsB),
        .VGA_Red_In(rgbB[11:8]), .VGA_Green_In(rgbB[7:4]),
        .VGA_Blue_In(rgbB[3:0]),
        .VGA_RED(rB), .VGA_GREEN(gB), .VGA_BLUE(bB),
        .VGA_HS(hsB), .VGA_VS(vsB)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel shown in cycle c came from the coordinate of cycle c-d-1 and
    // the colour the drawer presented in cycle c-1; any reset on the way
    // clears it.
    function automatic logic [13:0] exp_pins(input int c, input int d,
                                             input bit idle,
                                             input logic [11:0] rgbp);
        int m;
        bit fl;
        m = c - d - 1;
        fl = 1'b0;
        for (int j = m; j <= m + d; j++)
            if (rst_hist[j]) fl = 1'b1;
        if (fl) return {12'h000, idle, idle};
        return {actH[m] ? rgbp : 12'h000, hsH[m] ^ idle, vsH[m] ^ idle};
    endfunction

    initial begin
        int k, eh, ev, rpt, last_fs;
        bit fresh;
        logic [13:0] ea, eb;
        k = 0;
        last_fs = -1;
        fresh = 1'b1;
        rpt = 700 + $urandom_range(0, 60);
        RESET = 1'b1;
        rgbA = 12'h0;
        rgbB = 12'h0;
        rst_hist[0] = 1'b1;
        rgbA_hist[0] = 12'h0;
        rgbB_hist[0] = 12'h0;
        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk);
            if (rst_hist[c-1]) k = 0;
            else k++;
            #1;
            eh = k % HT;
            ev = (k / HT) % VT;
            actH[c] = (eh < HA) && (ev < VA);
            hsH[c] = (eh >= HA + HF) && (eh < HA + HF + HS);
            vsH[c] = (ev >= VA + VF) && (ev < VA + VF + VS);
            if (c >= 8) begin
                chk("hA", 32'(hA), 32'(eh));
                chk("vA", 32'(vA), 32'(ev));
                chk("fsA", 32'(fsA), 32'(eh == 0 && ev == 0));
                chk("hB", 32'(hB), 32'(eh));
                chk("vB", 32'(vB), 32'(ev));
                chk("fsB", 32'(fsB), 32'(eh == 0 && ev == 0));
                ea = exp_pins(c, DA, 1'b0, rgbA_hist[c-1]);
                eb = exp_pins(c, DB, 1'b1, rgbB_hist[c-1]);
                chk("rgbA", 32'({rA, gA, bA}), 32'(ea[13:2]));
                chk("hsA", 32'(hsA), 32'(ea[1]));
                chk("vsA", 32'(vsA), 32'(ea[0]));
                chk("rgbB", 32'({rB, gB, bB}), 32'(eb[13:2]));
                chk("hsB", 32'(hsB), 32'(eb[1]));
                chk("vsB", 32'(vsB), 32'(eb[0]));
                if (rst_hist[c-1]) fresh = 1'b1;
                if (fsA === 1'b1) begin
                    if (!fresh && last_fs >= 0)
                        chk("frame_period", 32'(c - last_fs), 32'(HT * VT));
                    last_fs = c;
                    fresh = 1'b0;
                end
            end
            RESET = (c < 4) || (c == rpt);
            rst_hist[c] = RESET;
            rgbA = 12'($urandom);
            rgbB = 12'($urandom);
            rgbA_hist[c] = rgbA;
            rgbB_hist[c] = rgbB;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
